pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline; sits beside the forwarding logic.

---
 rtl/pipeline_ctrl_if.sv | 38 +++
 rtl/pipeline_ctrl.sv | 94 +++++++++
 tb/tb_pipeline_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and its stall/flush sequencer.
// The master side is the sequencer; the slave side is the datapath and MDU.
interface pipeline_ctrl_if;
  logic [4:0] id_rs1_addr_i;
  logic [4:0] id_rs2_addr_i;
  logic       id_uses_rs1_i;
  logic       id_uses_rs2_i;
  logic [4:0] ex_rd_i;
  logic       ex_mem_read_i;
  logic       ex_mdu_op_i;
  logic       ex_branch_taken_i;
  logic       mdu_done_i;
  logic       dmem_req_i;
  logic       dmem_ready_i;
  logic       stall_if_o;
  logic       stall_id_o;
  logic       stall_ex_o;
  logic       flush_if_id_o;
  logic       flush_id_ex_o;
  logic       mdu_start_o;
  logic       mdu_ack_o;

  modport master (
    input  id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
    input  ex_rd_i, ex_mem_read_i, ex_mdu_op_i, ex_branch_taken_i,
    input  mdu_done_i, dmem_req_i, dmem_ready_i,
    output stall_if_o, stall_id_o, stall_ex_o,
    output flush_if_id_o, flush_id_ex_o, mdu_start_o, mdu_ack_o
  );

  modport slave (
    output id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
    output ex_rd_i, ex_mem_read_i, ex_mdu_op_i, ex_branch_taken_i,
    output mdu_done_i, dmem_req_i, dmem_ready_i,
    input  stall_if_o, stall_id_o, stall_ex_o,
    input  flush_if_id_o, flush_id_ex_o, mdu_start_o, mdu_ack_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch redirects,
// MUL/DIV occupancy and data-memory wait states, plus a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipeline_ctrl_if.master  ctl,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic {RUN, MDU_BUSY} state_t;

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  logic mem_wait, load_use, rs1_hit, rs2_hit;
  logic stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, mdu_start, mdu_ack;

  assign mem_wait = ctl.dmem_req_i & ~ctl.dmem_ready_i;
  assign rs1_hit  = ctl.id_uses_rs1_i & (ctl.ex_rd_i == ctl.id_rs1_addr_i);
  assign rs2_hit  = ctl.id_uses_rs2_i & (ctl.ex_rd_i == ctl.id_rs2_addr_i);
  assign load_use = ctl.ex_mem_read_i & (ctl.ex_rd_i != 5'd0) & (rs1_hit | rs2_hit);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  // A memory wait freezes the whole sequencer, including a pending MDU accept.
  always_comb begin
    state_next = state_reg;
    if (!mem_wait) begin
      case (state_reg)
        RUN:      if (ctl.ex_mdu_op_i) state_next = MDU_BUSY;
        MDU_BUSY: if (ctl.mdu_done_i)  state_next = RUN;
        default:  state_next = RUN;
      endcase
    end
  end

  // Outputs are forced low while reset is held so nothing leaks out mid-reset.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    mdu_start   = 1'b0;
    mdu_ack     = 1'b0;
    if (!rst_i) begin
      if (mem_wait) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end else if (state_reg == MDU_BUSY) begin
        if (ctl.mdu_done_i) begin
          mdu_ack = 1'b1;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end
      end else if (ctl.ex_mdu_op_i) begin
        mdu_start = 1'b1;
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
      end else if (ctl.ex_branch_taken_i) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        stall_if    = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  assign ctl.stall_if_o    = stall_if;
  assign ctl.stall_id_o    = stall_id;
  assign ctl.stall_ex_o    = stall_ex;
  assign ctl.flush_if_id_o = flush_if_id;
  assign ctl.flush_id_ex_o = flush_id_ex;
  assign ctl.mdu_start_o   = mdu_start;
  assign ctl.mdu_ack_o     = mdu_ack;

  always_ff @(posedge clk_i) begin
    if (rst_i)                         cnt_reg <= '0;
    else if (stall_if && cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
  end

  assign stall_cycles_o = cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed check of pipeline_ctrl against a rule-level model of the
// hazard priorities, MDU handshake and saturating stall counter.
module tb_pipeline_ctrl;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ctl            (bus.master),
    .stall_cycles_o (stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: is an MDU operation outstanding, and the expected counter value
  bit mdl_busy = 1'b0;
  int mdl_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.id_rs1_addr_i = 5'd0; bus.id_rs2_addr_i = 5'd0;
    bus.id_uses_rs1_i = 1'b0; bus.id_uses_rs2_i = 1'b0;
    bus.ex_rd_i = 5'd0; bus.ex_mem_read_i = 1'b0; bus.ex_mdu_op_i = 1'b0;
    bus.ex_branch_taken_i = 1'b0; bus.mdu_done_i = 1'b0;
    bus.dmem_req_i = 1'b0; bus.dmem_ready_i = 1'b0;
  endtask

  // Expected {stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, mdu_start, mdu_ack}
  function automatic logic [6:0] expect_out();
    bit wait_mem, hazard;
    wait_mem = bus.dmem_req_i && !bus.dmem_ready_i;
    hazard = bus.ex_mem_read_i && bus.ex_rd_i != 0 &&
             ((bus.id_uses_rs1_i && bus.ex_rd_i == bus.id_rs1_addr_i) ||
              (bus.id_uses_rs2_i && bus.ex_rd_i == bus.id_rs2_addr_i));
    if (rst)                      return 7'b000_00_00;
    if (wait_mem)                 return 7'b111_00_00;
    if (mdl_busy)                 return bus.mdu_done_i ? 7'b000_00_01 : 7'b111_00_00;
    if (bus.ex_mdu_op_i)          return 7'b111_00_10;
    if (bus.ex_branch_taken_i)    return 7'b000_11_00;
    if (hazard)                   return 7'b100_01_00;
    return 7'b000_00_00;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input string tag);
    logic [6:0] exp, got;
    bit wait_mem;
    @(negedge clk);
    exp = expect_out();
    got = {bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.flush_if_id_o,
           bus.flush_id_ex_o, bus.mdu_start_o, bus.mdu_ack_o};
    check({tag, ".out"}, 32'(got), 32'(exp));
    check({tag, ".cnt"}, 32'(stall_cycles), 32'(mdl_cnt));
    check({tag, ".excl"}, 32'((got[6] & got[3]) | (got[5] & got[2])), 32'd0);
    $display("cyc %s in={mdu%0b ld%0b br%0b done%0b req%0b rdy%0b rst%0b} out=%b cnt=%0d",
             tag, bus.ex_mdu_op_i, bus.ex_mem_read_i, bus.ex_branch_taken_i, bus.mdu_done_i,
             bus.dmem_req_i, bus.dmem_ready_i, rst, got, stall_cycles);
    wait_mem = bus.dmem_req_i && !bus.dmem_ready_i;
    @(posedge clk);
    if (rst) begin
      mdl_busy = 1'b0;
      mdl_cnt  = 0;
    end else begin
      if (exp[6] && mdl_cnt < (1 << CNT_W) - 1) mdl_cnt++;
      if (!wait_mem) mdl_busy = mdl_busy ? !bus.mdu_done_i : bus.ex_mdu_op_i;
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step("rst");
    rst = 1'b0;
    step("idle");
    check("rst_cnt", 32'(stall_cycles), 32'd0);

    // lw x5 in EX, ID reads rs2=x5
    bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd5;
    bus.id_rs2_addr_i = 5'd5; bus.id_uses_rs2_i = 1'b1;
    step("lu");
    idle();
    step("lu_after");
    check("lu_cnt", 32'(stall_cycles), 32'd1);

    // load to x0 with ID reading x0
    bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd0;
    bus.id_rs1_addr_i = 5'd0; bus.id_uses_rs1_i = 1'b1;
    step("lu_x0");
    idle();

    // MUL with done after four busy cycles
    bus.ex_mdu_op_i = 1'b1;
    step("mul_start");
    for (int i = 0; i < 4; i++) step("mul_busy");
    bus.mdu_done_i = 1'b1;
    step("mul_ack");
    idle();
    step("mul_run");

    // done coincides with a two-cycle memory wait
    bus.ex_mdu_op_i = 1'b1;
    step("div_start");
    bus.mdu_done_i = 1'b1; bus.dmem_req_i = 1'b1; bus.dmem_ready_i = 1'b0;
    step("div_wait0");
    step("div_wait1");
    bus.dmem_ready_i = 1'b1;
    step("div_ack");
    bus.mdu_done_i = 1'b0; bus.ex_mdu_op_i = 1'b0; bus.dmem_req_i = 1'b0;
    step("div_run");

    // taken branch alongside a load-use hazard
    bus.ex_branch_taken_i = 1'b1; bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd7;
    bus.id_rs1_addr_i = 5'd7; bus.id_uses_rs1_i = 1'b1;
    step("br_lu");
    idle();

    // reset while MDU busy
    bus.ex_mdu_op_i = 1'b1;
    step("rb_start");
    step("rb_busy");
    idle();
    rst = 1'b1;
    step("rb_rst");
    rst = 1'b0;
    bus.mdu_done_i = 1'b1;
    step("rb_noack");
    idle();

    // saturate the counter with a long memory wait
    bus.dmem_req_i = 1'b1;
    for (int i = 0; i < 40; i++) step("sat");
    check("sat_max", 32'(stall_cycles), 32'((1 << CNT_W) - 1));
    idle();
    step("sat_end");

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 11);
      bus.ex_mdu_op_i       = (r == 0) || ($urandom_range(0, 63) == 0);
      bus.ex_mem_read_i     = (r >= 1 && r <= 4);
      bus.ex_branch_taken_i = (r == 5) || ($urandom_range(0, 31) == 0);
      bus.ex_rd_i       = 5'($urandom_range(0, 3));
      bus.id_rs1_addr_i = 5'($urandom_range(0, 3));
      bus.id_rs2_addr_i = 5'($urandom_range(0, 3));
      bus.id_uses_rs1_i = 1'($urandom_range(0, 1));
      bus.id_uses_rs2_i = 1'($urandom_range(0, 1));
      bus.mdu_done_i    = ($urandom_range(0, 9) < 3);
      bus.dmem_req_i    = ($urandom_range(0, 9) < 3);
      bus.dmem_ready_i  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      step("rnd");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
